// File: rtl/pipelined_adder.sv
// pipelined_adder: DATA_WIDTH-bit adder split into SEGMENTS carry slices, one
// register stage per slice. Define PIPELINED_ADDER_SUB_EN for the sub port.
module pipelined_adder #(
  parameter int DATA_WIDTH = 8,
  parameter int SEGMENTS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [DATA_WIDTH-1:0] data2,
  input  logic                  carry_in,
`ifdef PIPELINED_ADDER_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH:0]   result
);

  localparam int SW = DATA_WIDTH / SEGMENTS;

  if (SEGMENTS < 1 || SEGMENTS > DATA_WIDTH ||
      (DATA_WIDTH % SEGMENTS) != 0) begin : g_bad_cfg
    $error("pipelined_adder: bad DATA_WIDTH/SEGMENTS");
  end

  logic                sub_en;
  logic [SEGMENTS-1:0] vld;
  logic [SEGMENTS-1:0] vld_nxt;
  logic [SEGMENTS:0]   vin;
  logic [SEGMENTS:0]   rdy;

`ifdef PIPELINED_ADDER_SUB_EN
  assign sub_en = sub;
`else
  assign sub_en = 1'b0;
`endif

  assign rdy[SEGMENTS] = out_ready;
  assign vin           = {vld, in_valid};

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_rdy
    assign rdy[k] = !vld[k] || rdy[k+1];
  end

  // An empty stage loads even when downstream stalls, so bubbles collapse.
  always_comb begin
    vld_nxt = vld;
    for (int k = 0; k < SEGMENTS; k++) begin
      if (rdy[k]) vld_nxt[k] = vin[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld <= '0;
    else        vld <= vld_nxt;
  end

  for (genvar k = 0; k < SEGMENTS; k++) begin : g_stg
    localparam int IW = (SEGMENTS - k) * SW;

    logic [IW-1:0]         a_i;
    logic [IW-1:0]         b_i;
    logic                  c_i;
    logic                  co;
    logic [SW-1:0]         s;
    logic [(k+1)*SW-1:0]   sum_d;
    logic [(k+1)*SW-1:0]   sum_q;
    logic                  c_q;

    if (k == 0) begin : g_in
      assign a_i   = data1;
      assign b_i   = data2 ^ {DATA_WIDTH{sub_en}};
      assign c_i   = carry_in | sub_en;
      assign sum_d = s;
    end else begin : g_in
      assign a_i   = g_stg[k-1].g_p.a_q;
      assign b_i   = g_stg[k-1].g_p.b_q;
      assign c_i   = g_stg[k-1].c_q;
      assign sum_d = {s, g_stg[k-1].sum_q};
    end

    assign {co, s} = {1'b0, a_i[SW-1:0]}
                   + {1'b0, b_i[SW-1:0]}
                   + {{SW{1'b0}}, c_i};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        c_q   <= 1'b0;
      end else if (rdy[k]) begin
        sum_q <= sum_d;
        c_q   <= co;
      end
    end

    // Operand bits still waiting for their slice ride along with the stage.
    if (IW > SW) begin : g_p
      logic [IW-SW-1:0] a_q;
      logic [IW-SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k]) begin
          a_q <= a_i[IW-1:SW];
          b_q <= b_i[IW-1:SW];
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[SEGMENTS-1];
  assign result    = {g_stg[SEGMENTS-1].c_q, g_stg[SEGMENTS-1].sum_q};

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for pipelined_adder.
// Expected sums are queued on accept and popped on output transfer.
module tb_pipelined_adder;
  localparam int DW = 8;
  localparam int SG = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] data1 = '0;
  logic [DW-1:0] data2 = '0;
  logic          carry_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW:0]   result;
  logic          sub = 1'b0;
  logic          rnd_bp = 1'b0;

  int total = 0;
  int bad = 0;
  logic [DW:0] sb[$];

  always #5 clk = ~clk;

  pipelined_adder #(.DATA_WIDTH(DW), .SEGMENTS(SG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data1(data1),
    .data2(data2),
    .carry_in(carry_in),
`ifdef PIPELINED_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] model(input logic [DW-1:0] a,
                                        input logic [DW-1:0] b,
                                        input logic c, input logic s);
    logic [DW:0] r;
    if (s) r = {1'b0, a} + {1'b0, ~b} + (DW+1)'(1);
    else   r = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, c};
    return r;
  endfunction

  // Handshake inputs settle at posedge+1, so the negedge sees next edge's transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("spurious_out", {23'd0, result}, 32'hffff_ffff);
        end else begin
          logic [DW:0] e;
          e = sb.pop_front();
          check("sb_result", {23'd0, result}, {23'd0, e});
        end
      end
`ifdef PIPELINED_ADDER_SUB_EN
      if (in_valid && in_ready) sb.push_back(model(data1, data2, carry_in, sub));
`else
      if (in_valid && in_ready) sb.push_back(model(data1, data2, carry_in, 1'b0));
`endif
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic c, output int n);
    logic acc;
    data1 = a;
    data2 = b;
    carry_in = c;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 60);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      tick();
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    int n;
    int lat;
    logic [DW-1:0] s1 [5] = '{8'd2, 8'd9, 8'd10, 8'd10, 8'd0};
    logic [DW-1:0] s2 [5] = '{8'd5, 8'd9, 8'd15, 8'd5, 8'd0};

    repeat (3) tick();
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_result", {23'd0, result}, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 1);

    send(8'd3, 8'd4, 1'b0, n);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, SG);
    check("lat_result", {23'd0, result}, 32'd7);
    drain();

    send(8'd255, 8'd255, 1'b1, n);
    send(8'd15, 8'd1, 1'b0, n);
    drain();

    for (int i = 0; i < 5; i++) begin
      send(s1[i], s2[i], 1'b0, n);
      check("stream_in_ready", n, 1);
    end
    drain();

    out_ready = 1'b0;
    send(s1[0], s2[0], 1'b0, n);
    send(s1[1], s2[1], 1'b0, n);
    data1 = s1[2];
    data2 = s2[2];
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 0);
      check("bp_out_valid", {31'd0, out_valid}, 1);
      check("bp_hold", {23'd0, result}, 32'd7);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 2; i < 5; i++) send(s1[i], s2[i], 1'b0, n);
    drain();

    send(8'd1, 8'd2, 1'b0, n);
    send(8'd3, 8'd3, 1'b0, n);
    in_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    check("midrst_result", {23'd0, result}, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", {31'd0, in_ready}, 1);
    send(8'd20, 8'd30, 1'b1, n);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("midrst_first", {23'd0, result}, 32'd51);
    drain();

`ifdef PIPELINED_ADDER_SUB_EN
    sub = 1'b1;
    send(8'd10, 8'd15, 1'b0, n);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("sub_lt", {23'd0, result}, 32'h0fb);
    drain();
    send(8'd15, 8'd10, 1'b1, n);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("sub_ge", {23'd0, result}, 32'h105);
    drain();
`endif

    rnd_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
`ifdef PIPELINED_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      send(DW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), n);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    in_valid = 1'b0;
    rnd_bp = 1'b0;
    tick();
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
